bus_rr_arbiter: RTL

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Four-master round-robin arbiter in front of a single slave bus.
//   An owner keeps the bus while its req stays high. It is pre-empted after
//   QUANTUM completed transfers if another master is waiting.
//   A strobe that waits TIMEOUT cycles for ready ends in a one-cycle TOUT
//   state. TOUT returns an error response to the owner and sets the sticky
//   err flag.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   req[3:0]        per-master request, held for the whole ownership period
//   gnt[3:0]        one-hot grant (all-zero in IDLE)
//   m_a/m_d[127:0]  per-master address / write data, master i at [32i+31:32i]
//   m_we/m_rd[3:0]  per-master write / read strobes
//   m_spo[127:0]    per-master read data (only the owner's slot is non-zero)
//   m_ready[3:0]    per-master transfer-complete
//   a, d[31:0]      slave address / write data
//   we, rd          slave strobes
//   spo[31:0]       slave read data
//   ready           slave transfer-complete
//   err_clr         clears err (a timeout in the same cycle wins)
//   err, err_id     sticky timeout flag and the index of the master that timed out
//   irq             mirror of err
module bus_rr_arbiter #(
  parameter int QUANTUM = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  output logic [3:0]   gnt,
  input  logic [127:0] m_a,
  input  logic [127:0] m_d,
  input  logic [3:0]   m_we,
  input  logic [3:0]   m_rd,
  output logic [127:0] m_spo,
  output logic [3:0]   m_ready,
  output logic [31:0]  a,
  output logic [31:0]  d,
  output logic         we,
  output logic         rd,
  input  logic [31:0]  spo,
  input  logic         ready,
  input  logic         err_clr,
  output logic         err,
  output logic [1:0]   err_id,
  output logic         irq
);

  localparam int QW = (QUANTUM < 2) ? 1 : $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {IDLE, OWN, TOUT} state_t;

  state_t        r_state;
  logic [1:0]    r_owner;
  logic [1:0]    r_last;
  logic [QW-1:0] r_qcnt;
  logic [10:0]   r_wcnt;
  logic          r_err;
  logic [1:0]    r_err_id;

  logic          w_own_we;
  logic          w_own_rd;
  logic          w_busy;
  logic          w_xfer_done;
  logic          w_waiting;
  logic [QW-1:0] w_qnext;
  logic          w_qexp;
  logic [10:0]   w_wnext;
  logic          w_tout;
  logic [3:0]    w_owner_oh;
  logic          w_others;
  logic [1:0]    w_pick;

  assign w_owner_oh  = 4'b0001 << r_owner;
  assign w_own_we    = m_we[r_owner];
  assign w_own_rd    = m_rd[r_owner];
  assign w_busy      = w_own_we | w_own_rd;
  assign w_xfer_done = (r_state == OWN) && w_busy && ready;
  assign w_waiting   = (r_state == OWN) && w_busy && !ready;
  assign w_qnext     = r_qcnt + QW'(1);
  assign w_qexp      = (QUANTUM != 0) && w_xfer_done && (w_qnext == QW'(QUANTUM));
  assign w_wnext     = r_wcnt + 11'd1;
  assign w_tout      = w_waiting && (w_wnext == 11'(TIMEOUT));
  assign w_others    = |(req & ~w_owner_oh);

  // Round-robin pick: scan last+1 .. last+4 (mod 4) so the previous owner
  // is considered last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found  = 1'b0;
    idx    = r_last;
    w_pick = r_last;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!found && req[idx]) begin
        w_pick = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= 2'd0;
      r_last   <= 2'd3;
      r_qcnt   <= '0;
      r_wcnt   <= '0;
      r_err    <= 1'b0;
      r_err_id <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_qcnt <= '0;
          r_wcnt <= '0;
          if (|req) begin
            r_owner <= w_pick;
            r_state <= OWN;
          end
        end
        OWN: begin
          // A sole requester wraps the quantum count instead of expiring.
          // A master that starts requesting later then waits at most
          // QUANTUM transfers.
          if (w_xfer_done)
            r_qcnt <= w_qexp ? '0 : w_qnext;
          r_wcnt <= w_waiting ? w_wnext : '0;
          if (!req[r_owner]) begin
            r_state <= IDLE;
            r_last  <= r_owner;
          end else if (w_tout) begin
            r_state <= TOUT;
          end else if (w_qexp && w_others) begin
            r_state <= IDLE;
            r_last  <= r_owner;
          end
        end
        TOUT: begin
          r_state  <= IDLE;
          r_last   <= r_owner;
          r_err_id <= r_owner;
        end
        default: r_state <= IDLE;
      endcase

      if (r_state == TOUT)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
    end
  end

  // Bus steering: the slave sees only the owner, and only the owner sees the slave.
  always_comb begin
    gnt     = 4'b0000;
    a       = 32'd0;
    d       = 32'd0;
    we      = 1'b0;
    rd      = 1'b0;
    m_spo   = 128'd0;
    m_ready = 4'b0000;
    case (r_state)
      OWN: begin
        gnt                         = w_owner_oh;
        a                           = m_a[{r_owner, 5'b0} +: 32];
        d                           = m_d[{r_owner, 5'b0} +: 32];
        we                          = w_own_we;
        rd                          = w_own_rd;
        m_spo[{r_owner, 5'b0} +: 32] = spo;
        m_ready[r_owner]            = ready;
      end
      TOUT: begin
        gnt                         = w_owner_oh;
        m_spo[{r_owner, 5'b0} +: 32] = 32'hFFFF_FFFF;
        m_ready[r_owner]            = 1'b1;
      end
      default: ;
    endcase
  end

  assign err    = r_err;
  assign err_id = r_err_id;
  assign irq    = r_err;

endmodule
